// File: rtl/keypad_pkg.sv
// Shared key codes, candidate classes and FSM states for the keypad scanner
// and for the grid control block that consumes key_pulse.
package keypad_pkg;

    localparam int         KEY_VALID = 4;
    localparam logic [4:0] KEY_IDLE  = 5'b00000;

    localparam logic [3:0] KEY_0    = 4'h0;
    localparam logic [3:0] KEY_1    = 4'h1;
    localparam logic [3:0] KEY_2    = 4'h2;
    localparam logic [3:0] KEY_3    = 4'h3;
    localparam logic [3:0] KEY_4    = 4'h4;
    localparam logic [3:0] KEY_5    = 4'h5;
    localparam logic [3:0] KEY_6    = 4'h6;
    localparam logic [3:0] KEY_7    = 4'h7;
    localparam logic [3:0] KEY_8    = 4'h8;
    localparam logic [3:0] KEY_9    = 4'h9;
    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_B    = 4'hB;
    localparam logic [3:0] KEY_C    = 4'hC;
    localparam logic [3:0] KEY_D    = 4'hD;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        KEY   = 2'd1,
        MULTI = 2'd2
    } cand_class_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESSED = 1'b1
    } key_state_t;

    // Physical matrix position to key code; row 0 is the top row.
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        case ({row, col})
            4'h0:    key_code = KEY_1;
            4'h1:    key_code = KEY_2;
            4'h2:    key_code = KEY_3;
            4'h3:    key_code = KEY_A;
            4'h4:    key_code = KEY_4;
            4'h5:    key_code = KEY_5;
            4'h6:    key_code = KEY_6;
            4'h7:    key_code = KEY_B;
            4'h8:    key_code = KEY_7;
            4'h9:    key_code = KEY_8;
            4'hA:    key_code = KEY_9;
            4'hB:    key_code = KEY_C;
            4'hC:    key_code = KEY_STAR;
            4'hD:    key_code = KEY_0;
            4'hE:    key_code = KEY_HASH;
            default: key_code = KEY_D;
        endcase
    endfunction

endpackage

// File: rtl/keypad_scan_core.sv
// Column scanner: synchronizes the rows, walks the columns one slot at a time
// and reports one candidate (NONE / KEY(code) / MULTI) per full 4-column scan.
module keypad_scan_core
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic        scan_done,
    output cand_class_t cand_class,
    output logic [3:0]  cand_code
);

    localparam int               SLOT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);

    logic [3:0]        row_sync_p0;
    logic [3:0]        row_sync_p1;
    logic [SLOT_W-1:0] slot_cnt;
    logic [1:0]        col_idx;
    logic [1:0]        acc_cnt;
    logic [3:0]        acc_code;

    logic              slot_end;
    logic [1:0]        row_first;
    logic [2:0]        row_hits;
    logic [1:0]        acc_cnt_nxt;
    logic [3:0]        acc_code_nxt;
    cand_class_t       class_nxt;

    // Pressed-key count only needs to distinguish 0, 1 and "2 or more".
    function automatic logic [1:0] sat_acc(input logic [1:0] acc, input logic [2:0] hits);
        logic [2:0] sum;
        sum = {1'b0, acc} + hits;
        return (sum >= 3'd2) ? 2'd2 : sum[1:0];
    endfunction

    assign slot_end = (slot_cnt == SLOT_LAST);

    always_comb begin
        row_first = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (row_sync_p1[r]) begin
                row_first = 2'(r);
            end
        end
        row_hits = {2'b00, row_sync_p1[0]} + {2'b00, row_sync_p1[1]}
                 + {2'b00, row_sync_p1[2]} + {2'b00, row_sync_p1[3]};
        acc_cnt_nxt  = sat_acc(acc_cnt, row_hits);
        acc_code_nxt = acc_code;
        if ((acc_cnt == 2'd0) && (row_sync_p1 != 4'b0000)) begin
            acc_code_nxt = key_code(row_first, col_idx);
        end
        case (acc_cnt_nxt)
            2'd0:    class_nxt = NONE;
            2'd1:    class_nxt = KEY;
            default: class_nxt = MULTI;
        endcase
    end

    // Row synchronizer stages p0/p1, then slot / column sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_sync_p0 <= 4'b0000;
            row_sync_p1 <= 4'b0000;
            slot_cnt    <= '0;
            col_idx     <= 2'd0;
            col_out     <= 4'b0001;
            acc_cnt     <= 2'd0;
            acc_code    <= 4'h0;
            scan_done   <= 1'b0;
            cand_class  <= NONE;
            cand_code   <= 4'h0;
        end else begin
            row_sync_p0 <= row_in;
            row_sync_p1 <= row_sync_p0;
            scan_done   <= 1'b0;
            if (slot_end) begin
                slot_cnt <= '0;
                col_idx  <= col_idx + 2'd1;
                col_out  <= {col_out[2:0], col_out[3]};
                if (col_idx == 2'd3) begin
                    scan_done  <= 1'b1;
                    cand_class <= class_nxt;
                    cand_code  <= (class_nxt == KEY) ? acc_code_nxt : 4'h0;
                    acc_cnt    <= 2'd0;
                    acc_code   <= 4'h0;
                end else begin
                    acc_cnt  <= acc_cnt_nxt;
                    acc_code <= acc_code_nxt;
                end
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/keypad_pulse_gen.sv
// 4x4 keypad front end: debounces per-scan candidates and emits one
// {valid, code} pulse per confirmed press, plus a held indication.
module keypad_pulse_gen
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [4:0] key_pulse,
    output logic       key_held
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

    logic              scan_done;
    cand_class_t       cand_class;
    logic [3:0]        cand_code;

    logic [CNT_W-1:0]  stable_cnt;
    cand_class_t       prev_class;
    logic [3:0]        prev_code;
    key_state_t        state;

    logic              same_cand;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              confirmed;
    key_state_t        state_nxt;
    logic [4:0]        pulse_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    endfunction

    keypad_scan_core #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk        (clk),
        .rst        (rst),
        .row_in     (row_in),
        .col_out    (col_out),
        .scan_done  (scan_done),
        .cand_class (cand_class),
        .cand_code  (cand_code)
    );

    always_comb begin
        same_cand = (cand_class == prev_class) && (cand_code == prev_code);
        cnt_nxt   = same_cand ? sat_inc(stable_cnt) : CNT_W'(1);
        confirmed = scan_done && (cnt_nxt == CNT_MAX);
    end

    // Debounce stage: one update per completed scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_cnt <= '0;
            prev_class <= NONE;
            prev_code  <= 4'h0;
        end else if (scan_done) begin
            stable_cnt <= cnt_nxt;
            if (!same_cand) begin
                prev_class <= cand_class;
                prev_code  <= cand_code;
            end
        end
    end

    // A different key or a chord while PRESSED is ignored: only a debounced
    // all-released scan re-arms the detector.
    always_comb begin
        state_nxt = state;
        pulse_nxt = KEY_IDLE;
        case (state)
            IDLE: begin
                if (confirmed && (cand_class == KEY)) begin
                    state_nxt            = PRESSED;
                    pulse_nxt[KEY_VALID] = 1'b1;
                    pulse_nxt[3:0]       = cand_code;
                end
            end
            PRESSED: begin
                if (confirmed && (cand_class == NONE)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            key_pulse <= KEY_IDLE;
        end else begin
            state     <= state_nxt;
            key_pulse <= pulse_nxt;
        end
    end

    assign key_held = (state == PRESSED);

endmodule

// File: tb/tb_keypad_pulse_gen.sv
// Bench for keypad_pulse_gen: drives a modelled key matrix one full scan at a
// time and compares pulses / held state against a scan-level history model.
module tb_keypad_pulse_gen;

    localparam int SD  = 4;
    localparam int DEB = 3;

    localparam logic [3:0] KEYCODE [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                            4'h4, 4'h5, 4'h6, 4'hB,
                                            4'h7, 4'h8, 4'h9, 4'hC,
                                            4'hE, 4'h0, 4'hF, 4'hD};
    localparam int K1 = 1, K4 = 4, K5 = 5, K6 = 6, KB = 7, K8 = 9, KA = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [4:0] key_pulse;
    logic       key_held;
    logic [15:0] keys = 16'h0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sec_pulses = 0;
    logic [4:0] last_code = 5'b0;
    int pulse_cyc = 0;

    int   hist[$];
    bit   m_pressed = 1'b0;
    int   exp_npulse = 0;
    logic [4:0] exp_code = 5'b0;

    keypad_pulse_gen #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_pulse (key_pulse),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Pull-down matrix: a row reads high when a pressed key sits on a driven column.
    always_comb begin
        row_in = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            row_in[r] = |(keys[r*4 +: 4] & col_out);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int cand_of(input logic [15:0] m);
        int n;
        n = $countones(m);
        if (n == 0) return 16;
        if (n > 1) return 17;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) return int'(KEYCODE[i]);
        end
        return 16;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_pressed  = 1'b0;
        exp_npulse = 0;
        exp_code   = 5'b0;
    endtask

    // Caller is on the negedge right after a scan boundary (or reset release).
    // The pulse caused by the previous scan shows up inside this window.
    task automatic do_scan(input logic [15:0] mask);
        int npulse;
        logic [4:0] code;
        logic prev_v;
        int c;
        bit run;
        keys   = mask;
        npulse = 0;
        code   = 5'b0;
        prev_v = key_pulse[4];
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            cyc++;
            check("col_rot", {28'b0, col_out}, 32'(4'b0001 << ((k % 16) / 4)));
            check("pulse_gap", {31'b0, prev_v & key_pulse[4]}, 32'd0);
            if (key_pulse != 5'b0) begin
                npulse++;
                code = key_pulse;
                sec_pulses++;
                last_code = key_pulse;
                pulse_cyc = cyc;
            end
            prev_v = key_pulse[4];
        end
        check("pulse_cnt", npulse, exp_npulse);
        check("pulse_code", {27'b0, code}, {27'b0, exp_code});
        check("key_held", {31'b0, key_held}, {31'b0, m_pressed});

        c = cand_of(mask);
        hist.push_back(c);
        exp_npulse = 0;
        exp_code   = 5'b0;
        if (hist.size() >= DEB) begin
            run = 1'b1;
            for (int j = 0; j < DEB; j++) begin
                if (hist[hist.size() - 1 - j] != c) run = 1'b0;
            end
            if (run && !m_pressed && c < 16) begin
                exp_npulse = 1;
                exp_code   = {1'b1, 4'(c)};
                m_pressed  = 1'b1;
            end else if (run && m_pressed && c == 16) begin
                m_pressed = 1'b0;
            end
        end
    endtask

    initial begin
        int press_cyc;
        int hold;
        logic [15:0] m;
        int a;
        int b;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_col", {28'b0, col_out}, 32'h1);
        check("rst_pulse", {27'b0, key_pulse}, 32'h0);
        check("rst_held", {31'b0, key_held}, 32'h0);
        rst = 1'b0;
        model_reset();

        // Idle, no keys for 512 cycles
        sec_pulses = 0;
        repeat (32) do_scan(16'h0);
        check("idle_pulses", sec_pulses, 0);

        // Key 2 sustained, then released
        sec_pulses = 0;
        press_cyc  = cyc;
        repeat (6) do_scan(16'(1) << K1);
        check("k2_pulses", sec_pulses, 1);
        check("k2_code", {27'b0, last_code}, {27'b0, 5'b10010});
        check("k2_latency_ok", {31'b0, (pulse_cyc - press_cyc) <= (DEB + 1) * 4 * SD + 3}, 32'd1);
        check("k2_held", {31'b0, key_held}, 32'd1);
        repeat (4) do_scan(16'h0);
        check("k2_released", {31'b0, key_held}, 32'd0);

        // Key B bouncing for 2 scans at a time, then held
        sec_pulses = 0;
        repeat (5) begin
            repeat (2) do_scan(16'(1) << KB);
            do_scan(16'h0);
        end
        check("bounce_pulses", sec_pulses, 0);
        repeat (10) do_scan(16'(1) << KB);
        check("kb_pulses", sec_pulses, 1);
        check("kb_code", {27'b0, last_code}, {27'b0, 5'b11011});
        repeat (4) do_scan(16'h0);

        // Keys 4 and 6 together
        sec_pulses = 0;
        repeat (20) do_scan((16'(1) << K4) | (16'(1) << K6));
        check("multi_pulses", sec_pulses, 0);
        check("multi_held", {31'b0, key_held}, 32'd0);
        repeat (2) do_scan(16'h0);

        // Key 8, then 8+5, release, then A
        sec_pulses = 0;
        repeat (5) do_scan(16'(1) << K8);
        check("k8_code", {27'b0, last_code}, {27'b0, 5'b11000});
        repeat (5) do_scan((16'(1) << K8) | (16'(1) << K5));
        check("k8k5_pulses", sec_pulses, 1);
        repeat (3) do_scan(16'h0);
        repeat (5) do_scan(16'(1) << KA);
        check("ka_pulses", sec_pulses, 2);
        check("ka_code", {27'b0, last_code}, {27'b0, 5'b11010});
        repeat (4) do_scan(16'h0);

        // Key 2 held across a reset
        sec_pulses = 0;
        repeat (4) do_scan(16'(1) << K1);
        check("pre_rst_pulses", sec_pulses, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_pulse", {27'b0, key_pulse}, 32'h0);
        check("mid_rst_held", {31'b0, key_held}, 32'h0);
        check("mid_rst_col", {28'b0, col_out}, 32'h1);
        repeat (3) begin
            @(negedge clk);
            check("in_rst_pulse", {27'b0, key_pulse}, 32'h0);
            check("in_rst_held", {31'b0, key_held}, 32'h0);
            check("in_rst_col", {28'b0, col_out}, 32'h1);
        end
        rst = 1'b0;
        model_reset();
        sec_pulses = 0;
        repeat (5) do_scan(16'(1) << K1);
        check("post_rst_pulses", sec_pulses, 1);
        check("post_rst_code", {27'b0, last_code}, {27'b0, 5'b10010});
        repeat (4) do_scan(16'h0);

        // Randomized key activity
        for (int s = 0; s < 80; s += hold) begin
            a = $urandom_range(0, 9);
            if (a < 4) begin
                m = 16'h0;
            end else if (a < 8) begin
                m = 16'(1) << $urandom_range(0, 15);
            end else begin
                a = $urandom_range(0, 15);
                b = (a + $urandom_range(1, 15)) % 16;
                m = (16'(1) << a) | (16'(1) << b);
            end
            hold = $urandom_range(1, 5);
            repeat (hold) do_scan(m);
        end
        repeat (4) do_scan(16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
